adbg_ahb3_biu: RTL
==================

ADBG_AHB3_BIU -- requirements
Module: adbg_ahb3_biu

Interface
REQ-001 SHALL have parameter HADDR_SIZE, default 32, AHB address width.
REQ-002 SHALL have parameter HDATA_SIZE, default 32, AHB data width; legal values are 32 and 64.
REQ-003 SHALL have parameter TIMEOUT, default 255, HREADY-low cycle limit (used only under REQ-031).
REQ-004 SHALL have port HCLK  in  1  clock, all logic on rising edge.
REQ-005 SHALL have port HRESETn  in  1  reset; one clock; reset is synchronous and active-low.
REQ-006 SHALL have port biu_req  in  1  access request, sampled only while biu_rdy=1.
REQ-007 SHALL have port biu_addr  in  HADDR_SIZE  byte address.
REQ-008 SHALL have port biu_we  in  1  1=write, 0=read.
REQ-009 SHALL have port biu_size  in  3  HSIZE encoding, HSIZE8..HSIZE64.
REQ-010 SHALL have port biu_wdata  in  64  write data, right-aligned.
REQ-011 SHALL have port biu_rdata  out  64  read data, right-aligned, zero-extended.
REQ-012 SHALL have port biu_rdy  out  1  idle, able to accept a request.
REQ-013 SHALL have port biu_done  out  1  one-cycle completion pulse.
REQ-014 SHALL have port biu_err  out  1  error status, valid with biu_done.
REQ-015 SHALL have AHB3-Lite master ports HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK (out) and HRDATA, HREADY, HRESP (in), widths per HADDR_SIZE/HDATA_SIZE.

Function
REQ-016 SHALL implement FSM states IDLE, ADDR, DATA, RESP.
REQ-017 IDLE: biu_rdy=1; on biu_req=1 SHALL latch addr/we/size/wdata and go ADDR, or go RESP with error if request illegal (REQ-022).
REQ-018 ADDR: SHALL drive HSEL=1, HTRANS=NONSEQ, HADDR, HWRITE, HSIZE; on HREADY=1 go DATA.
REQ-019 DATA: SHALL drive HTRANS=IDLE, HSEL=0, HWDATA; on HREADY=1 capture read lane and HRESP, go RESP.
REQ-020 RESP: SHALL assert biu_done for exactly one cycle, biu_rdy=1, then IDLE; a new biu_req in RESP is accepted as in IDLE.
REQ-021 Zero-wait latency: biu_req sampled at edge k -> NONSEQ in cycle k+1 -> data phase k+2 -> biu_done in cycle k+3.
REQ-022 Illegal request (biu_size > log2(HDATA_SIZE/8), or biu_addr not aligned to size) SHALL produce no bus cycle and biu_done=biu_err=1 in the next cycle.
REQ-023 Write: HWDATA SHALL replicate the low 2^size bytes of biu_wdata across all byte lanes.
REQ-024 Read: biu_rdata SHALL equal the addressed HRDATA lane shifted to bit 0, upper bits zero; held until next completion.
REQ-025 biu_err SHALL equal HRESP sampled with HREADY=1 in DATA; otherwise 0.
REQ-026 HBURST SHALL be HBURST_SINGLE, HPROT 4'b0011, HMASTLOCK 0, at all times.
REQ-027 HADDR/HWRITE/HSIZE SHALL hold stable while HREADY=0 in ADDR; HWDATA stable while HREADY=0 in DATA.

Reset
REQ-028 While HRESETn=0 at a clock edge: state IDLE, HTRANS=IDLE, HSEL=0, biu_done=0, biu_err=0, biu_rdata=0, HADDR/HWDATA=0, HWRITE=0, HSIZE=HSIZE8.
REQ-029 Reset mid-transfer SHALL abandon the transfer with no biu_done.

Configuration
REQ-030 Macro ADBG_AHB3_BIU_TIMEOUT_EN SHALL select the watchdog.
REQ-031 Defined: counter SHALL count consecutive HREADY=0 cycles in ADDR/DATA; at TIMEOUT, force HTRANS=IDLE, HSEL=0, go RESP with biu_err=1; counter clears on HREADY=1 or state change.
REQ-032 Undefined: no counter; BIU SHALL wait on HREADY indefinitely.

Structure
REQ-033 FSM state typedef and HPROT debug constant SHALL be added to adbg_ahb3_pkg; HTRANS/HSIZE/HBURST/HRESP constants SHALL be taken from it.
REQ-034 Lane steering (write replicate, read extract) SHALL be sub-module adbg_ahb3_biu_lane.

Verification
REQ-035 32-bit bus, write size=2, addr 0x1000_0004, wdata 0xDEADBEEF, HREADY=1 -> NONSEQ cycle k+1, HWDATA 0xDEADBEEF k+2, biu_done k+3, biu_err=0.
REQ-036 Read size=0, addr 0x...03, HRDATA 0xAABBCCDD -> biu_rdata=0x0000_0000_0000_00AA.
REQ-037 Slave inserts 3 wait states in DATA -> HWDATA stable, biu_done 3 cycles later than REQ-021.
REQ-038 HDATA_SIZE=32, size=3 request, or size=2 at addr 0x2 -> no HTRANS=NONSEQ, biu_done=biu_err=1 next cycle.
REQ-039 Two-cycle HRESP=1 error response -> biu_err=1 with biu_done; with TIMEOUT_EN, TIMEOUT=4, HREADY held 0 -> abort after 4 cycles, biu_err=1.
REQ-040 HRESETn=0 during DATA -> outputs per REQ-028 next edge, no biu_done.

Source files
------------

// File: rtl/adbg_ahb3_pkg.sv
// Shared AHB3-Lite encodings and BIU types for the debug-unit AHB master.
// Also carries the request-legality helper used by the BIU front end.
package adbg_ahb3_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE8  = 3'b000;
  localparam logic [2:0] HSIZE16 = 3'b001;
  localparam logic [2:0] HSIZE32 = 3'b010;
  localparam logic [2:0] HSIZE64 = 3'b011;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic HRESP_OKAY = 1'b0;
  localparam logic HRESP_ERR  = 1'b1;

  // Data access, privileged: the debug unit is never an opcode fetch.
  localparam logic [3:0] HPROT_DEBUG = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } biu_state_t;

  // A request is legal when it fits the bus and is naturally aligned.
  function automatic logic req_legal(input logic [2:0] size,
                                     input logic [2:0] addr_lo,
                                     input logic [2:0] max_size);
    logic [2:0] mask;
    if (size > max_size) return 1'b0;
    mask = 3'((4'd1 << size) - 4'd1);
    return (addr_lo & mask) == 3'b000;
  endfunction

endpackage

// File: rtl/adbg_ahb3_biu_if.sv
// AHB3-Lite bus bundle between the debug BIU (master) and the fabric (slave).
interface adbg_ahb3_biu_if #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32
);
  logic                  HSEL;
  logic [HADDR_SIZE-1:0] HADDR;
  logic [HDATA_SIZE-1:0] HWDATA;
  logic [HDATA_SIZE-1:0] HRDATA;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic [1:0]            HTRANS;
  logic                  HMASTLOCK;
  logic                  HREADY;
  logic                  HRESP;

  modport master (
    output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/adbg_ahb3_biu_lane.sv
// Byte-lane steering: replicate write data across lanes, extract the addressed
// read lane down to bit 0 with the bytes above the access size cleared.
module adbg_ahb3_biu_lane #(
  parameter int HDATA_SIZE = 32,
  parameter int OFFW       = $clog2(HDATA_SIZE / 8)
) (
  input  logic [2:0]            size,
  input  logic [OFFW-1:0]       offset,
  input  logic [63:0]           wdata,
  input  logic [HDATA_SIZE-1:0] hrdata,
  output logic [HDATA_SIZE-1:0] hwdata,
  output logic [63:0]           rdata
);
  localparam int LANES = HDATA_SIZE / 8;

  logic [HDATA_SIZE-1:0] shifted;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    hwdata = '0;
    for (int i = 0; i < LANES; i++)
      hwdata[8*i +: 8] = wdata[8*(i & ((1 << size) - 1)) +: 8];
  end

  assign shifted = hrdata >> {offset, 3'b000};

  always_comb begin
    rdata = '0;
    for (int i = 0; i < LANES; i++)
      if (i < (1 << size)) rdata[8*i +: 8] = shifted[8*i +: 8];
  end

endmodule

// File: rtl/adbg_ahb3_biu.sv
// Debug-unit AHB3-Lite single-transfer bus interface unit.
// Optional HREADY watchdog: define ADBG_AHB3_BIU_TIMEOUT_EN.
module adbg_ahb3_biu
  import adbg_ahb3_pkg::*;
#(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,

  input  logic                  biu_req,
  input  logic [HADDR_SIZE-1:0] biu_addr,
  input  logic                  biu_we,
  input  logic [2:0]            biu_size,
  input  logic [63:0]           biu_wdata,
  output logic [63:0]           biu_rdata,
  output logic                  biu_rdy,
  output logic                  biu_done,
  output logic                  biu_err,

  adbg_ahb3_biu_if.master       ahb
);
  localparam int         OFFW     = $clog2(HDATA_SIZE / 8);
  localparam logic [2:0] MAX_SIZE = 3'(OFFW);

  if (TIMEOUT < 1 || (HDATA_SIZE != 32 && HDATA_SIZE != 64)) begin : g_bad_cfg
    $error("adbg_ahb3_biu: unsupported HDATA_SIZE or TIMEOUT");
  end

  biu_state_t            state, state_nx;
  logic [HADDR_SIZE-1:0] addr_r;
  logic                  we_r;
  logic [2:0]            size_r;
  logic [63:0]           wdata_r;
  logic [63:0]           rdata_r;
  logic                  err_r;

  logic                  legal, accept, capture, wd_expire;
  logic [HDATA_SIZE-1:0] lane_hwdata;
  logic [63:0]           lane_rdata;

  assign legal = req_legal(biu_size, biu_addr[2:0], MAX_SIZE);

`ifdef ADBG_AHB3_BIU_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            bus_busy;

  assign bus_busy  = (state == ST_ADDR) || (state == ST_DATA);
  assign wd_expire = bus_busy && !ahb.HREADY && (wd_cnt == WD_W'(TIMEOUT - 1));

  always_ff @(posedge HCLK) begin
    if (!HRESETn || ahb.HREADY || !bus_busy || state_nx != state) wd_cnt <= '0;
    else                                                            wd_cnt <= wd_cnt + 1'b1;
  end
`else
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    capture  = 1'b0;
    case (state)
      ST_IDLE, ST_RESP: begin
        if (biu_req) begin
          accept   = 1'b1;
          state_nx = legal ? ST_ADDR : ST_RESP;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (ahb.HREADY)     state_nx = ST_DATA;
        else if (wd_expire) state_nx = ST_RESP;
      end
      ST_DATA: begin
        if (ahb.HREADY) begin
          capture  = 1'b1;
          state_nx = ST_RESP;
        end else if (wd_expire) begin
          state_nx = ST_RESP;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      // NOTE: the data holding registers are reset too, since they drive
      // HADDR/HWDATA/biu_rdata directly and must read zero out of reset.
      state   <= ST_IDLE;
      addr_r  <= '0;
      we_r    <= 1'b0;
      size_r  <= HSIZE8;
      wdata_r <= '0;
      rdata_r <= '0;
      err_r   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        if (legal) begin
          addr_r  <= biu_addr;
          we_r    <= biu_we;
          size_r  <= biu_size;
          wdata_r <= biu_wdata;
          err_r   <= 1'b0;
        end else begin
          err_r <= 1'b1;
        end
      end
      if (capture) begin
        if (!we_r) rdata_r <= lane_rdata;
        err_r <= (ahb.HRESP == HRESP_ERR);
      end
      if (wd_expire) err_r <= 1'b1;
    end
  end

  adbg_ahb3_biu_lane #(
    .HDATA_SIZE (HDATA_SIZE)
  ) u_lane (
    .size   (size_r),
    .offset (addr_r[OFFW-1:0]),
    .wdata  (wdata_r),
    .hrdata (ahb.HRDATA),
    .hwdata (lane_hwdata),
    .rdata  (lane_rdata)
  );

  // Address/control and write data come straight from held registers, so
  // they stay stable across any number of wait states.
  assign ahb.HSEL      = (state == ST_ADDR);
  assign ahb.HTRANS    = (state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign ahb.HADDR     = addr_r;
  assign ahb.HWRITE    = we_r;
  assign ahb.HSIZE     = size_r;
  assign ahb.HWDATA    = lane_hwdata;
  assign ahb.HBURST    = HBURST_SINGLE;
  assign ahb.HPROT     = HPROT_DEBUG;
  assign ahb.HMASTLOCK = 1'b0;

  assign biu_rdy   = (state == ST_IDLE) || (state == ST_RESP);
  assign biu_done  = (state == ST_RESP);
  assign biu_err   = (state == ST_RESP) && err_r;
  assign biu_rdata = rdata_r;

endmodule
